// File: rtl/sm_pkg.sv
// Shared types and constants for the stepper-motor phase sequencer.
package sm_pkg;

    // Index into the 8-entry half-step phase table.
    typedef logic [2:0] phase_idx_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Coil drive {A, B, nA, nB}; entry 0 is the rightmost element.
    localparam logic [7:0][3:0] PHASE_TAB = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // Index step size. Full-step from an odd (two-phase-on) index jumps 2;
    // from an even index it moves 1 so the next position is two-phase-on.
    function automatic logic [1:0] step_mag(input logic half, input phase_idx_t idx);
        return (half || !idx[0]) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/sm_lim_debounce.sv
// Limit-switch conditioning: 2-FF synchroniser followed by a stability filter.
module sm_lim_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Synchronise, then accept the new level only after DEB_CYC consecutive
    // differing samples; any return to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != deb) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sm_phase_seq.sv
// Stepper-motor coil phase sequencer: step-edge detect, limit blocking,
// signed position tracking and idle hold-current reduction.
module sm_phase_seq
    import sm_pkg::*;
#(
    parameter int POS_W    = 24,
    parameter int HOLD_CYC = 50000000,
    parameter int DEB_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drv_pulse,
    input  logic                    dir,
    input  logic                    half_step,
    input  logic                    drv_en_SM,
    input  logic                    lim_fwd,
    input  logic                    lim_rev,
    input  logic                    pos_clr,
    output logic [3:0]              phase,
    output logic signed [POS_W-1:0] pos,
    output logic                    step_ack,
    output logic                    fault_lim,
    output logic                    hold_low
);
    localparam int             HW       = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYC);

    logic                    pulse_q, req_q, dir_q;
    logic                    deb_fwd, deb_rev;
    logic                    blocked, accept;
    logic [1:0]              mag;
    phase_idx_t              idx, idx_nxt;
    logic signed [POS_W-1:0] pos_nxt;
    logic [HW-1:0]           hold_cnt;

    sm_lim_debounce #(.DEB_CYC(DEB_CYC)) u_deb_fwd (
        .clk (clk), .rst (rst), .raw (lim_fwd), .deb (deb_fwd)
    );

    sm_lim_debounce #(.DEB_CYC(DEB_CYC)) u_deb_rev (
        .clk (clk), .rst (rst), .raw (lim_rev), .deb (deb_rev)
    );

    // Decide whether the pending request steps, and where idx/pos land.
    always_comb begin
        blocked = (dir_q == DIR_FWD) ? deb_fwd : deb_rev;
        accept  = req_q & drv_en_SM & ~blocked;
        mag     = step_mag(half_step, idx);
        idx_nxt = idx;
        pos_nxt = pos;
        if (accept) begin
            if (dir_q == DIR_FWD) begin
                idx_nxt = idx + phase_idx_t'(mag);
                pos_nxt = pos + POS_W'(mag);
            end else begin
                idx_nxt = idx - phase_idx_t'(mag);
                pos_nxt = pos - POS_W'(mag);
            end
        end
    end

    // Request capture, step commit, fault latch, hold timer and phase drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q   <= 1'b0;
            req_q     <= 1'b0;
            dir_q     <= 1'b0;
            idx       <= '0;
            pos       <= '0;
            phase     <= '0;
            step_ack  <= 1'b0;
            fault_lim <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            pulse_q  <= drv_pulse;
            req_q    <= drv_pulse & ~pulse_q;
            dir_q    <= dir;
            idx      <= idx_nxt;
            step_ack <= accept;
            phase    <= drv_en_SM ? PHASE_TAB[idx_nxt] : 4'b0000;
            // A clear request wins over a same-cycle step for pos and fault.
            if (pos_clr) begin
                pos       <= '0;
                fault_lim <= 1'b0;
            end else begin
                pos <= pos_nxt;
                if (req_q & drv_en_SM & blocked)
                    fault_lim <= 1'b1;
            end
            if (accept)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_low = (hold_cnt == HOLD_MAX);

endmodule

// File: tb/tb_sm_phase_seq.sv
// Bench for sm_phase_seq: behavioural model compared every cycle, directed
// scenarios with literal expectations, then randomized stimulus.
module tb_sm_phase_seq;
    localparam int POS_W    = 8;
    localparam int HOLD_CYC = 200;
    localparam int DEB_CYC  = 16;
    localparam int POS_MAX  = 2 ** (POS_W - 1) - 1;
    localparam int POS_MIN  = -(2 ** (POS_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_pulse = 1'b0, dir = 1'b0, half_step = 1'b1, drv_en_SM = 1'b1;
    logic lim_fwd = 1'b0, lim_rev = 1'b0, pos_clr = 1'b0;
    logic [3:0]              phase;
    logic signed [POS_W-1:0] pos;
    logic step_ack, fault_lim, hold_low;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    sm_phase_seq #(.POS_W(POS_W), .HOLD_CYC(HOLD_CYC), .DEB_CYC(DEB_CYC)) dut (
        .clk(clk), .rst(rst), .drv_pulse(drv_pulse), .dir(dir), .half_step(half_step),
        .drv_en_SM(drv_en_SM), .lim_fwd(lim_fwd), .lim_rev(lim_rev), .pos_clr(pos_clr),
        .phase(phase), .pos(pos), .step_ack(step_ack), .fault_lim(fault_lim),
        .hold_low(hold_low)
    );

    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int   m_idx, m_pos, m_hold, m_d;
    bit   m_fault, m_ack, m_req, m_dirq, m_prev, m_live = 0, m_acc;
    logic [3:0] m_phase;
    bit   m_s1 [2], m_s2 [2], m_deb [2], m_raw [2];
    int   m_run [2];

    function automatic int wrap(input int v);
        if (v > POS_MAX) return v - 2 ** POS_W;
        if (v < POS_MIN) return v + 2 ** POS_W;
        return v;
    endfunction

    // Model evaluated on every rising edge from pre-edge values.
    always @(posedge clk) begin
        if (rst) begin
            m_idx = 0; m_pos = 0; m_hold = 0; m_fault = 0; m_ack = 0;
            m_req = 0; m_dirq = 0; m_prev = 0; m_phase = 4'b0000;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            end
        end else begin
            m_acc = 0;
            if (m_req && drv_en_SM) begin
                if (m_dirq ? m_deb[0] : m_deb[1]) begin
                    m_fault = 1;
                end else begin
                    m_acc = 1;
                    m_d = (half_step || (m_idx % 2 == 0)) ? 1 : 2;
                    if (!m_dirq) m_d = -m_d;
                    m_idx = (m_idx + m_d + 8) % 8;
                    m_pos = wrap(m_pos + m_d);
                end
            end
            if (pos_clr) begin
                m_pos = 0; m_fault = 0;
            end
            m_hold  = m_acc ? 0 : ((m_hold < HOLD_CYC) ? m_hold + 1 : HOLD_CYC);
            m_phase = drv_en_SM ? tab[m_idx] : 4'b0000;
            m_ack   = m_acc;
            m_req   = drv_pulse && !m_prev;
            m_dirq  = dir;
            m_prev  = drv_pulse;
            m_raw[0] = lim_fwd;
            m_raw[1] = lim_rev;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB_CYC) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = m_raw[i];
            end
        end
        m_live = 1;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        if (m_live) begin
            chk("m_phase", int'(phase), int'(m_phase));
            chk("m_pos", int'(pos), m_pos);
            chk("m_step_ack", int'(step_ack), int'(m_ack));
            chk("m_fault_lim", int'(fault_lim), int'(m_fault));
            chk("m_hold_low", int'(hold_low), int'(m_hold == HOLD_CYC));
        end
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (step_ack === 1'b1) ack_cnt++;
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; drv_pulse = 1'b0; pos_clr = 1'b0;
        lim_fwd = 1'b0; lim_rev = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic d, input int hi, input int lo);
        dir = d; drv_pulse = 1'b1;
        repeat (hi) tick();
        drv_pulse = 1'b0;
        repeat (lo) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_pos", int'(pos), 0);
        chk("reset_fault", int'(fault_lim), 0);
        chk("reset_hold", int'(hold_low), 0);

        // Half-step forward walk; first edge checks the one-cycle latency.
        half_step = 1'b1; drv_en_SM = 1'b1; dir = 1'b1;
        chk("idle_phase", int'(phase), 4'b1000);
        ack_cnt = 0;
        drv_pulse = 1'b1;
        tick();
        chk("lat_ack_early", int'(step_ack), 0);
        tick();
        chk("lat_ack", int'(step_ack), 1);
        chk("lat_phase", int'(phase), 4'b1100);
        drv_pulse = 1'b0; tick(); tick();
        repeat (9) pulse(1'b1, 2, 2);
        chk("walk_pos", int'(pos), 10);
        chk("walk_phase", int'(phase), 4'b0100);
        chk("walk_acks", ack_cnt, 10);

        // Full-step reverse from idx 0: 7, 5, 3.
        do_reset();
        half_step = 1'b0;
        repeat (3) pulse(1'b0, 2, 2);
        chk("full_rev_pos", int'(pos), -5);
        chk("full_rev_phase", int'(phase), 4'b0110);

        // Forward limit blocks forward step, reverse step still accepted.
        do_reset();
        half_step = 1'b1;
        lim_fwd = 1'b1;
        repeat (DEB_CYC + 3) tick();
        ack_cnt = 0;
        pulse(1'b1, 2, 2);
        chk("lim_block_ack", ack_cnt, 0);
        chk("lim_block_pos", int'(pos), 0);
        chk("lim_fault", int'(fault_lim), 1);
        pulse(1'b0, 2, 2);
        chk("lim_away_pos", int'(pos), -1);
        chk("lim_away_phase", int'(phase), 4'b1001);
        lim_fwd = 1'b0;

        // Bouncing limit never debounces; all forward steps accepted.
        do_reset();
        dir = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (c % 5 == 0) lim_fwd = ~lim_fwd;
            drv_pulse = (c % 6 < 2);
            tick();
        end
        drv_pulse = 1'b0; lim_fwd = 1'b0;
        tick();
        chk("bounce_fault", int'(fault_lim), 0);
        chk("bounce_pos", int'(pos), 20);

        // Hold-current timer and enable gating.
        do_reset();
        repeat (HOLD_CYC + 5) tick();
        chk("hold_set", int'(hold_low), 1);
        dir = 1'b1; drv_pulse = 1'b1;
        tick();
        chk("hold_still", int'(hold_low), 1);
        tick();
        chk("hold_drop", int'(hold_low), 0);
        chk("hold_drop_ack", int'(step_ack), 1);
        drv_pulse = 1'b0; tick();
        drv_en_SM = 1'b0;
        tick();
        chk("dis_phase", int'(phase), 0);
        pulse(1'b1, 2, 2);
        chk("dis_pos", int'(pos), 1);
        chk("dis_fault", int'(fault_lim), 0);
        drv_en_SM = 1'b1;
        tick();

        // pos_clr coinciding with an accepted step while faulted.
        do_reset();
        repeat (3) pulse(1'b1, 2, 2);
        lim_rev = 1'b1;
        repeat (DEB_CYC + 3) tick();
        pulse(1'b0, 2, 2);
        chk("clr_pre_fault", int'(fault_lim), 1);
        chk("clr_pre_pos", int'(pos), 3);
        dir = 1'b1; drv_pulse = 1'b1;
        tick();
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        chk("clr_pos", int'(pos), 0);
        chk("clr_fault", int'(fault_lim), 0);
        chk("clr_ack", int'(step_ack), 1);
        chk("clr_phase", int'(phase), 4'b0010);
        drv_pulse = 1'b0; tick();
        lim_rev = 1'b0;

        // Two's-complement wrap at the positive end.
        do_reset();
        half_step = 1'b1;
        repeat (POS_MAX) pulse(1'b1, 1, 1);
        chk("wrap_pre", int'(pos), POS_MAX);
        half_step = 1'b0;
        pulse(1'b1, 2, 2);
        chk("wrap_pos", int'(pos), POS_MIN + 1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) drv_pulse = ~drv_pulse;
            dir       = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 60) == 0) half_step = ~half_step;
            if ($urandom_range(0, 150) == 0) drv_en_SM = ~drv_en_SM;
            if ($urandom_range(0, 40) == 0) lim_fwd = ~lim_fwd;
            if ($urandom_range(0, 40) == 0) lim_rev = ~lim_rev;
            pos_clr = ($urandom_range(0, 120) == 0);
            tick();
        end
        pos_clr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
